seq_fixmul_alu: RTL and testbench
=================================

Name: seq_fixmul_alu

Overview:
- Clocked, parametrised successor to the picoMIPS combinational ALU.
- Generalises operand width and fixed-point format. Adds SUB and handshaked, registered results.
- Replaces the single-cycle array multiplier with an iterative shift-add signed fractional multiplier, one bit per cycle.
- Sits between the register file and the writeback mux. The control FSM stalls the PC while busy is high.

Parameters:
- N, 8, operand/result width in bits (N >= 4).
- FRAC, 7, fractional bits of the MUL result (1 <= FRAC <= N-1). Defaults give Q1.7, i.e. result = product[14:7].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- func  input  2  op code: 00 ADD, 01 SUB, 10 MUL, 11 PASS_A
- a  input  N  operand A, two's complement
- b  input  N  operand B, two's complement
- busy  output  1  high while a MUL iterates
- done  output  1  one-cycle pulse; result/flags valid from this cycle
- result  output  N  registered result; holds until next completion
- flags  output  2  registered; [1]=N (result MSB), [0]=Z (result==0)

Behaviour:
- Reset (synchronous, active-high) at any edge:
  - state=IDLE, busy=0, done=0, result=0, flags=2'b01.
  - Aborts any in-flight MUL; no done pulse follows.
- States: IDLE, MUL_RUN.
- IDLE, start=1, func != MUL (request accepted at edge t):
  - result/flags written at edge t; done=1 during cycle t+1; state stays IDLE.
  - ADD: a+b mod 2^N. SUB: a-b mod 2^N. PASS_A: a.
- IDLE, start=1, func=MUL:
  - Capture |a|, |b|, sign=a[N-1]^b[N-1]; clear 2N-bit accumulator and counter.
  - Magnitudes are N-bit unsigned, so -2^(N-1) is handled correctly.
  - Go to MUL_RUN; busy=1 for cycles t+1..t+N.
- MUL_RUN:
  - Each cycle: if the multiplier LSB is set, add the shifted multiplicand to the accumulator; shift; increment counter.
  - After the N-th iteration, negate the product if sign=1, to get the 2N-bit signed product P.
  - result = P[FRAC+N-1:FRAC]: arithmetic truncation toward minus infinity, high bits discarded (wrap).
  - Write result/flags; done=1 in cycle t+N+1; busy=0; back to IDLE.
  - MUL latency is N+1 cycles from the start edge to done.
- start while busy=1: ignored; operands and func are not sampled.
- start in a cycle where done=1: accepted, so back-to-back issue is legal.
- done is never high at the same time as busy.
- func and operands are sampled only at acceptance; later changes have no effect.
- flags always reflect the final (post-saturation) result.
- Throughput: 1 op/cycle for ADD/SUB/PASS_A; 1 MUL per N+1 cycles.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined:
  - ADD/SUB signed overflow clamps result to 2^(N-1)-1 or -2^(N-1).
  - MUL clamps when P[2N-1:FRAC+N-1] is not all-equal (sign extension violated). Positive products clamp to max, negative to min.
  - Latency unchanged.
- Undefined: wrap-around as described in Behaviour. No extra logic is generated.

Test Plan (N=8, FRAC=7):
- Reset, then MUL a=0x40, b=0x40:
  - Expect busy high 8 cycles, then done pulse with result=0x20, flags=00.
  - Checks reset values result=0x00, flags=01 and the 9-cycle latency.
- MUL a=0xC0, b=0x40 -> result=0xE0, flags=10. MUL a=0xFF, b=0x01 -> result=0xFF (floor truncation).
- MUL a=0x80, b=0x80:
  - Without ALU_SATURATE_EN -> result=0x80, flags=10.
  - With it -> result=0x7F, flags=00.
- ADD a=0x7F, b=0x01:
  - Without macro -> 0x80, flags=10. With macro -> 0x7F.
  - Also SUB a=0x05, b=0x05 -> 0x00, flags=01, done one cycle after start.
- Start MUL, pulse start with ADD at cycle 3 of busy:
  - ADD is ignored; only the MUL done occurs.
  - Then issue ADD on the done cycle -> accepted, done the next cycle.
- Assert reset at cycle 4 of a MUL -> no done pulse, busy=0, result=0x00, flags=01 the following cycle.

Source files
------------

// File: rtl/seq_fixmul_alu.sv
// seq_fixmul_alu: clocked ALU with ADD, SUB, PASS_A and an iterative
// shift-add signed fractional multiplier (one multiplier bit per cycle).
// Results and flags are registered and announced by a one-cycle done pulse.
// busy stays high while a multiply iterates, so the core can stall the PC.
//
// Optional build macro: ALU_SATURATE_EN
//   defined   : ADD/SUB signed overflow and MUL range overflow clamp the
//               result to the most positive or most negative value
//   undefined : results wrap modulo 2^N
module seq_fixmul_alu #(
  parameter int N    = 8,
  parameter int FRAC = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   func,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [1:0]   flags
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  // Control state (reset)
  state_t          state_q, state_d;
  logic            done_q, done_d;
  logic [N-1:0]    result_q, result_d;
  logic [1:0]      flags_q, flags_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Multiplier datapath (no reset; always loaded when a MUL is accepted)
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic            sign_q, sign_d;

  // Combinational helpers
  logic [2*N-1:0]  acc_sum;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    mul_res;
  logic [N-1:0]    alu_res;
  logic            unused_prod;

  // Unsigned magnitude of an N-bit two's complement value. The most negative
  // input maps to 2^(N-1), which still fits in N unsigned bits.
  function automatic logic [N-1:0] abs_mag(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

`ifdef ALU_SATURATE_EN
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  // Signed add/subtract with clamping on overflow. One extra bit of headroom
  // makes overflow visible as a disagreement between the top two bits.
  function automatic logic [N-1:0] sat_addsub(input logic [N-1:0] x,
                                              input logic [N-1:0] y,
                                              input logic         sub);
    logic [N:0] w;
    w = sub ? ({x[N-1], x} - {y[N-1], y}) : ({x[N-1], x} + {y[N-1], y});
    if (w[N] != w[N-1]) begin
      return w[N] ? SAT_MIN : SAT_MAX;
    end
    return w[N-1:0];
  endfunction

  // Fixed-point product clamp. hi holds every product bit from the result
  // sign bit upward; if they are not all equal the value does not fit in N
  // bits and is clamped according to the product sign (hi MSB).
  function automatic logic [N-1:0] sat_mul(input logic [N-FRAC:0] hi,
                                           input logic [N-1:0]    field);
    if (!((hi == '0) || (hi == '1))) begin
      return hi[N-FRAC] ? SAT_MIN : SAT_MAX;
    end
    return field;
  endfunction
`endif

  // Single-cycle operations and formatting of the finished product
  always_comb begin
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod    = sign_q ? (~acc_sum + 1'b1) : acc_sum;

`ifdef ALU_SATURATE_EN
    mul_res = sat_mul(prod[2*N-1:FRAC+N-1], prod[FRAC+N-1:FRAC]);
`else
    mul_res = prod[FRAC+N-1:FRAC];
`endif

    alu_res = a;
    case (func)
`ifdef ALU_SATURATE_EN
      OP_ADD:  alu_res = sat_addsub(a, b, 1'b0);
      OP_SUB:  alu_res = sat_addsub(a, b, 1'b1);
`else
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
`endif
      OP_PASS: alu_res = a;
      default: alu_res = a;
    endcase
  end

  // Product bits outside the result field are only consulted for clamping
  assign unused_prod = ^{prod[2*N-1:FRAC+N], prod[FRAC-1:0]};

  // Next-state logic: accept requests in IDLE, iterate the multiplier in MUL_RUN
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (func == OP_MUL) begin
            mcand_d  = {{N{1'b0}}, abs_mag(a)};
            mplier_d = abs_mag(b);
            acc_d    = '0;
            cnt_d    = '0;
            sign_d   = a[N-1] ^ b[N-1];
            state_d  = MUL_RUN;
          end else begin
            result_d = alu_res;
            done_d   = 1'b1;
          end
        end
      end

      MUL_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          result_d = mul_res;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (done_d) begin
      flags_d = {result_d[N-1], (result_d == '0)};
    end
  end

  // Control and architectural output registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 2'b01;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
    end
  end

  // Multiplier operand and accumulator registers
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    sign_q   <= sign_d;
  end

  assign busy   = (state_q == MUL_RUN);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_seq_fixmul_alu.sv
// Testbench for seq_fixmul_alu (N=8, FRAC=7). Directed cases plus randomized
// back-to-back traffic compared against an integer-arithmetic reference model.
// Build with +define+ALU_SATURATE_EN to check the clamping variant.
module tb_seq_fixmul_alu;

  localparam int N    = 8;
  localparam int FRAC = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   func;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [1:0]   flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_fixmul_alu #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .start(start), .func(func), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  // Reference: signed integer arithmetic, floor shift for the fixed-point
  // product, then either clamp to the signed N-bit range or wrap.
  // Returns {flags, result}.
  function automatic logic [9:0] ref_op(input logic [1:0] f, input logic [7:0] x, input logic [7:0] y);
    longint sx, sy, v;
    logic [7:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f)
      2'd0: v = sx + sy;
      2'd1: v = sx - sy;
      2'd2: v = (sx * sy) >>> FRAC;
      default: v = sx;
    endcase
`ifdef ALU_SATURATE_EN
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
`endif
    r = v[7:0];
    return {r[7], (r == 8'h00), r};
  endfunction

  // Issue one request at the current falling edge and wait (bounded) for done.
  // Operands are scrambled after acceptance. Ends on the falling edge of the
  // done cycle so another request can be issued there.
  task automatic run_op(input logic [1:0] f, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int bcyc, output int overlap);
    start = 1'b1; func = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; func = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1; bcyc = 0; overlap = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(negedge clk);
      lat++;
    end
    if (done && busy) overlap = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; func = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (flags !== 2'b01) begin errors++; $display("FAIL reset_flags got=%b exp=01", flags); end
  endtask

  task automatic test_mul_basic();
    int lat, bcyc, ov;
    run_op(2'b10, 8'h40, 8'h40, lat, bcyc, ov);
    checks++; if (lat !== 9) begin errors++; $display("FAIL mul_latency got=%0d exp=9", lat); end
    checks++; if (bcyc !== 8) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=8", bcyc); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL mul_done_busy_overlap got=%0d exp=0", ov); end
    checks++; if (result !== 8'h20) begin errors++; $display("FAIL mul_40x40 got=%h exp=20", result); end
    checks++; if (flags !== 2'b00) begin errors++; $display("FAIL mul_40x40_flags got=%b exp=00", flags); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mul_signs();
    int lat, bcyc, ov;
    logic [7:0] exp_r;
    logic [1:0] exp_f;
    run_op(2'b10, 8'hC0, 8'h40, lat, bcyc, ov);
    checks++; if (result !== 8'hE0) begin errors++; $display("FAIL mul_C0x40 got=%h exp=E0", result); end
    checks++; if (flags !== 2'b10) begin errors++; $display("FAIL mul_C0x40_flags got=%b exp=10", flags); end
    run_op(2'b10, 8'hFF, 8'h01, lat, bcyc, ov);
    checks++; if (result !== 8'hFF) begin errors++; $display("FAIL mul_FFx01_floor got=%h exp=FF", result); end
    run_op(2'b10, 8'h80, 8'h80, lat, bcyc, ov);
`ifdef ALU_SATURATE_EN
    exp_r = 8'h7F; exp_f = 2'b00;
`else
    exp_r = 8'h80; exp_f = 2'b10;
`endif
    checks++; if (result !== exp_r) begin errors++; $display("FAIL mul_80x80 got=%h exp=%h", result, exp_r); end
    checks++; if (flags !== exp_f) begin errors++; $display("FAIL mul_80x80_flags got=%b exp=%b", flags, exp_f); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL mul_80x80_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_addsub();
    int lat, bcyc, ov;
    logic [7:0] exp_r;
    logic [1:0] exp_f;
    run_op(2'b00, 8'h7F, 8'h01, lat, bcyc, ov);
`ifdef ALU_SATURATE_EN
    exp_r = 8'h7F; exp_f = 2'b00;
`else
    exp_r = 8'h80; exp_f = 2'b10;
`endif
    checks++; if (result !== exp_r) begin errors++; $display("FAIL add_7F_01 got=%h exp=%h", result, exp_r); end
    checks++; if (flags !== exp_f) begin errors++; $display("FAIL add_7F_01_flags got=%b exp=%b", flags, exp_f); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
    run_op(2'b01, 8'h05, 8'h05, lat, bcyc, ov);
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL sub_05_05 got=%h exp=00", result); end
    checks++; if (flags !== 2'b01) begin errors++; $display("FAIL sub_05_05_flags got=%b exp=01", flags); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got=%0d exp=1", lat); end
    run_op(2'b11, 8'h9C, 8'h33, lat, bcyc, ov);
    checks++; if ({flags, result} !== {2'b10, 8'h9C}) begin
      errors++; $display("FAIL pass_a got=%b/%h exp=10/9c", flags, result);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, ov;
    ov = 0;
    start = 1'b1; func = 2'b10; a = 8'h40; b = 8'hC0;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; func = 2'b00; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done && busy) ov = 1;
    checks++; if (lat !== 9) begin errors++; $display("FAIL ignore_mul_latency got=%0d exp=9", lat); end
    checks++; if (result !== 8'hE0) begin errors++; $display("FAIL ignore_mul_result got=%h exp=E0", result); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL ignore_overlap got=%0d exp=0", ov); end
    start = 1'b1; func = 2'b00; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
    checks++; if ({flags, result} !== {2'b00, 8'h33}) begin
      errors++; $display("FAIL b2b_add got=%b/%h exp=00/33", flags, result);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_extra_done got=%b exp=0", done); end
  endtask

  task automatic test_abort();
    int dcount;
    start = 1'b1; func = 2'b10; a = 8'h40; b = 8'h40;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL abort_result got=%h exp=00", result); end
    checks++; if (flags !== 2'b01) begin errors++; $display("FAIL abort_flags got=%b exp=01", flags); end
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dcount); end
  endtask

  task automatic test_random();
    int lat, bcyc, ov;
    logic [1:0] f;
    logic [7:0] x, y;
    logic [9:0] exp;
    for (int i = 0; i < 60; i++) begin
      f = 2'($urandom);
      x = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
      y = ($urandom_range(0, 4) == 0) ? 8'h7F : 8'($urandom);
      exp = ref_op(f, x, y);
      run_op(f, x, y, lat, bcyc, ov);
      checks++; if ({flags, result} !== exp) begin
        errors++; $display("FAIL rand_op%0d f=%0d a=%h b=%h got=%b/%h exp=%b/%h", i, f, x, y, flags, result, exp[9:8], exp[7:0]);
      end
      checks++; if (lat !== ((f == 2'b10) ? 9 : 1)) begin
        errors++; $display("FAIL rand_lat%0d f=%0d got=%0d exp=%0d", i, f, lat, (f == 2'b10) ? 9 : 1);
      end
      checks++; if (ov !== 0) begin errors++; $display("FAIL rand_overlap%0d got=%0d exp=0", i, ov); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_signs();
    test_addsub();
    test_busy_ignore();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
